// File: rtl/secure_scan_ctrl_if.sv
// Scan-control bundle between test access, scan muxes and key-load logic.
// Parameters must match the attached secure_scan_ctrl instance.
interface secure_scan_ctrl_if #(
  parameter int NUM_CHAINS = 4,
  parameter int VIOL_W     = 8
);
  logic                  secure_mode;
  logic                  test_mode;
  logic [NUM_CHAINS-1:0] chain_sel;
  logic [NUM_CHAINS-1:0] enable_scan_in;
  logic [NUM_CHAINS-1:0] enable_scan_out;
  logic                  scan_mode;
  logic                  scan_flush;
  logic                  loadkey;
  logic                  locked;
  logic [VIOL_W-1:0]     viol_count;

  modport master (
    output secure_mode, test_mode, chain_sel,
    input  enable_scan_in, enable_scan_out, scan_mode,
    input  scan_flush, loadkey, locked, viol_count
  );

  modport slave (
    input  secure_mode, test_mode, chain_sel,
    output enable_scan_in, enable_scan_out, scan_mode,
    output scan_flush, loadkey, locked, viol_count
  );
endinterface

// File: rtl/secure_scan_ctrl.sv
// Secure-scan lock: OPEN -> FLUSH -> LOCKED, exit only via reset.
// Define SECSCAN_VIOL_CNT_EN to build the post-lock violation counter.
module secure_scan_ctrl #(
  parameter int NUM_CHAINS   = 4,
  parameter int FLUSH_CYCLES = 128,
  parameter int VIOL_W       = 8
) (
  input logic              clk,
  input logic              reset,
  secure_scan_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    OPEN   = 2'd0,
    FLUSH  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int CW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(FLUSH_CYCLES - 1);

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [NUM_CHAINS-1:0] en_in;
  logic [NUM_CHAINS-1:0] en_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= OPEN;
      cnt   <= '0;
    end else begin
      case (state)
        OPEN: begin
          if (bus.secure_mode) begin
            state <= FLUSH;
            cnt   <= CNT_INIT;
          end
        end
        FLUSH: begin
          if (cnt == '0) state <= LOCKED;
          else           cnt   <= cnt - 1'b1;
        end
        LOCKED:  state <= LOCKED;
        // unreachable encodings fail secure
        default: state <= LOCKED;
      endcase
    end
  end

  always_comb begin
    en_in          = '0;
    en_out         = '0;
    bus.scan_mode  = 1'b0;
    bus.scan_flush = 1'b0;
    bus.loadkey    = 1'b1;
    bus.locked     = 1'b1;
    case (state)
      OPEN: begin
        en_in         = bus.chain_sel;
        en_out        = bus.chain_sel;
        bus.scan_mode = bus.test_mode;
        bus.loadkey   = 1'b0;
        bus.locked    = 1'b0;
      end
      FLUSH: begin
        en_in          = '1;
        bus.scan_mode  = 1'b1;
        bus.scan_flush = 1'b1;
        bus.loadkey    = 1'b0;
        bus.locked     = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus.enable_scan_in  = en_in;
  assign bus.enable_scan_out = en_out;

`ifdef SECSCAN_VIOL_CNT_EN
  logic              tm_q;
  logic [VIOL_W-1:0] vcnt;

  // held-high test_mode across lock entry has tm_q=1, so no edge
  always_ff @(posedge clk) begin
    if (reset) begin
      tm_q <= 1'b0;
      vcnt <= '0;
    end else begin
      tm_q <= bus.test_mode;
      if (state == LOCKED && bus.test_mode && !tm_q
          && vcnt != {VIOL_W{1'b1}})
        vcnt <= vcnt + 1'b1;
    end
  end

  assign bus.viol_count = vcnt;
`else
  assign bus.viol_count = {VIOL_W{1'b0}};
`endif
endmodule

// File: tb/tb_secure_scan_ctrl.sv
// Scoreboard bench: directed stimulus queues expected outputs,
// a negedge monitor pops and compares against the DUT.
module tb_secure_scan_ctrl;
  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  always #5 clk = ~clk;

`ifdef SECSCAN_VIOL_CNT_EN
  localparam bit VEN = 1'b1;
`else
  localparam bit VEN = 1'b0;
`endif

  secure_scan_ctrl_if #(.NUM_CHAINS(4), .VIOL_W(8)) if_a ();
  secure_scan_ctrl_if #(.NUM_CHAINS(1), .VIOL_W(2)) if_b ();

  secure_scan_ctrl #(
    .NUM_CHAINS(4), .FLUSH_CYCLES(128), .VIOL_W(8)
  ) u_a (
    .clk(clk), .reset(rst_a), .bus(if_a)
  );

  secure_scan_ctrl #(
    .NUM_CHAINS(1), .FLUSH_CYCLES(1), .VIOL_W(2)
  ) u_b (
    .clk(clk), .reset(rst_b), .bus(if_b)
  );

  typedef struct {
    int          inst;
    string       name;
    logic [19:0] val;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [19:0] act(int inst);
    if (inst == 0)
      return {if_a.enable_scan_in, if_a.enable_scan_out,
              if_a.scan_mode, if_a.scan_flush,
              if_a.loadkey, if_a.locked, if_a.viol_count};
    return {3'b0, if_b.enable_scan_in, 3'b0, if_b.enable_scan_out,
            if_b.scan_mode, if_b.scan_flush,
            if_b.loadkey, if_b.locked, 6'b0, if_b.viol_count};
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [19:0] a;
      e = q.pop_front();
      a = act(e.inst);
      n_cmp++;
      if (a !== e.val) begin
        n_bad++;
        $display("FAIL %s: got %05h expected %05h", e.name, a, e.val);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_o(int inst, string n,
                          logic [3:0] esi, logic [3:0] eso,
                          logic sm, logic sf, logic lk, logic lc,
                          logic [7:0] vc);
    exp_t e;
    e.inst = inst;
    e.name = n;
    e.val  = {esi, eso, sm, sf, lk, lc, vc};
    q.push_back(e);
  endtask

  task automatic exp_flush(int inst, string n);
    expect_o(inst, n, (inst == 0) ? 4'hF : 4'h1, 4'h0,
             1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic exp_lock(int inst, string n, logic [7:0] vc);
    expect_o(inst, n, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, vc);
  endtask

  initial begin
    if_a.secure_mode = 1'b0;
    if_a.test_mode   = 1'b0;
    if_a.chain_sel   = 4'h0;
    if_b.secure_mode = 1'b0;
    if_b.test_mode   = 1'b0;
    if_b.chain_sel   = 1'b0;

    // reset state: OPEN equations
    step();
    expect_o(0, "reset_idle", 4'h0, 4'h0, 0, 0, 0, 0, 8'd0);
    step();
    rst_a = 1'b0;
    if_a.test_mode = 1'b1;
    if_a.chain_sel = 4'b0101;
    expect_o(0, "open_pass", 4'b0101, 4'b0101, 1, 0, 0, 0, 8'd0);
    step();
    if_a.test_mode = 1'b0;
    if_a.chain_sel = 4'b0011;
    expect_o(0, "open_pass2", 4'b0011, 4'b0011, 0, 0, 0, 0, 8'd0);

    // request, then reset at flush cycle 50
    if_a.secure_mode = 1'b1;
    step();
    if_a.secure_mode = 1'b0;
    if_a.chain_sel   = 4'b1010;
    for (int i = 1; i <= 50; i++) begin
      exp_flush(0, $sformatf("flush_a_%0d", i));
      if (i == 50) rst_a = 1'b1;
      step();
    end
    rst_a = 1'b0;
    if_a.test_mode = 1'b1;
    expect_o(0, "rst_mid_flush", 4'b1010, 4'b1010, 1, 0, 0, 0, 8'd0);

    // full flush with test_mode held high throughout
    if_a.secure_mode = 1'b1;
    step();
    if_a.secure_mode = 1'b0;
    if_a.chain_sel   = 4'b1111;
    for (int i = 1; i <= 128; i++) begin
      exp_flush(0, $sformatf("flush_b_%0d", i));
      step();
    end
    exp_lock(0, "locked_entry", 8'd0);
    step();
    exp_lock(0, "locked_hold", 8'd0);

    // three violation edges
    for (int t = 1; t <= 3; t++) begin
      if_a.test_mode = 1'b0;
      step();
      if_a.test_mode = 1'b1;
      step();
      exp_lock(0, $sformatf("viol_a_%0d", t), VEN ? 8'(t) : 8'd0);
    end
    if_a.test_mode = 1'b0;
    step();
    exp_lock(0, "viol_a_final", VEN ? 8'd3 : 8'd0);

    // small build: FLUSH_CYCLES=1, NUM_CHAINS=1, VIOL_W=2
    step();
    rst_b = 1'b0;
    if_b.chain_sel = 1'b1;
    expect_o(1, "b_open", 4'h1, 4'h1, 0, 0, 0, 0, 8'd0);
    if_b.secure_mode = 1'b1;
    step();
    if_b.secure_mode = 1'b0;
    exp_flush(1, "b_flush");
    step();
    exp_lock(1, "b_lock", 8'd0);
    step();
    exp_lock(1, "b_lock_hold", 8'd0);
    for (int t = 1; t <= 5; t++) begin
      if_b.test_mode = 1'b0;
      step();
      if_b.test_mode = 1'b1;
      step();
      exp_lock(1, $sformatf("b_viol_%0d", t),
               VEN ? 8'((t > 3) ? 3 : t) : 8'd0);
    end

    // reset from LOCKED clears the counter
    rst_b = 1'b1;
    step();
    rst_b = 1'b0;
    expect_o(1, "b_rst_locked", 4'h1, 4'h1, 1, 0, 0, 0, 8'd0);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
